scan_seq_416: RTL and testbench

SCAN_SEQ_416 -- requirements
Module: scan_seq_416

---
 rtl/scan_seq_pkg.sv | 18 +
 rtl/scan_seq_416_dwell_timer.sv | 33 +++
 rtl/scan_seq_416.sv | 120 ++++++++++++
 tb/tb_scan_seq_416.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_seq_pkg.sv
// Shared constants for the scan sequencer: FSM state encoding, code width and dwell counter width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package scan_seq_pkg;

  localparam int CODE_W  = 4;
  localparam int DWELL_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CODE_W-1:0] CODE_MIN = '0;
  localparam logic [CODE_W-1:0] CODE_MAX = '1;

endpackage

// File: rtl/scan_seq_416_dwell_timer.sv
// Dwell timer: counts 0..DWELL-1 while enabled and flags the last cycle of each dwell period.
// Latency: expire is high in the final cycle of every DWELL-cycle window after clear drops.
// Backpressure: none; clear holds the count at zero and suppresses expire.
module dwell_timer
  import scan_seq_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expire
);

  localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);
  localparam logic [DWELL_W-1:0] ONE  = DWELL_W'(1);

  logic [DWELL_W-1:0] cnt;

  // Count up to LAST and restart at zero, so every code advance starts a fresh window
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

  assign expire = !clear && (cnt == LAST);

endmodule

// File: rtl/scan_seq_416.sv
// Scan sequencer: sweeps a 4-bit decoder select code 0..15, holding each code DWELL cycles (optional SCAN_SEQ_DOWN_EN adds dir for down sweeps).
// Latency: start at edge k gives code 0000 with en=1 from cycle k+1; all outputs are registered.
// Backpressure: none; stop aborts a sweep on the next cycle, start is ignored while busy.
module scan_seq_416
  import scan_seq_pkg::*;
#(
  parameter int DWELL   = 4,
  parameter int ONESHOT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
`ifdef SCAN_SEQ_DOWN_EN
  input  logic dir,
`endif
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic en,
  output logic busy,
  output logic done
);

  state_t             state, state_nxt;
  logic [CODE_W-1:0]  code, code_nxt;
  logic               down;
  logic               dir_in;
  logic               expire;
  logic               at_end;
  logic               en_nxt, busy_nxt, done_nxt;

`ifdef SCAN_SEQ_DOWN_EN
  assign dir_in = dir;
`else
  assign dir_in = 1'b0;
`endif

  // Timer only runs in RUN; leaving RUN or entering it starts from a zero count
  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != RUN),
    .expire (expire)
  );

  assign at_end = down ? (code == CODE_MIN) : (code == CODE_MAX);

  // State, code, direction and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      code  <= '0;
      down  <= 1'b0;
      en    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      code  <= code_nxt;
      if (state == IDLE && start) begin
        down <= dir_in;
      end
      en    <= en_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Next state and next code; stop outranks dwell expiry and completion
  always_comb begin
    state_nxt = state;
    code_nxt  = code;
    case (state)
      IDLE: begin
        code_nxt = '0;
        if (start) begin
          state_nxt = RUN;
          code_nxt  = dir_in ? CODE_MAX : CODE_MIN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
          code_nxt  = '0;
        end else if (expire) begin
          if (at_end && (ONESHOT != 0)) begin
            state_nxt = DONE;
            code_nxt  = '0;
          end else begin
            // Modulo-16 arithmetic gives the continuous wrap for free
            code_nxt = down ? (code - 4'd1) : (code + 4'd1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        code_nxt  = '0;
      end
      default: begin
        state_nxt = IDLE;
        code_nxt  = '0;
      end
    endcase
  end

  // Output values decoded from the next state so they can be registered alongside it
  always_comb begin
    en_nxt   = (state_nxt == RUN);
    busy_nxt = (state_nxt == RUN);
    done_nxt = (state_nxt == DONE);
  end

  assign A = code[0];
  assign B = code[1];
  assign C = code[2];
  assign D = code[3];

endmodule

// File: tb/tb_scan_seq_416.sv
// Testbench for scan_seq_416: directed scenarios plus randomized stimulus against a sweep-position model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_scan_seq_416;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, stop = 1'b0, dir = 1'b0;

  logic A0, B0, C0, D0, en0, busy0, done0;
  logic A1, B1, C1, D1, en1, busy1, done1;
  logic [6:0] v0, v1;
  assign v0 = {D0, C0, B0, A0, en0, busy0, done0};
  assign v1 = {D1, C1, B1, A1, en1, busy1, done1};

  int n_checks = 0;
  int n_fail   = 0;

  scan_seq_416 #(.DWELL(4), .ONESHOT(1)) u0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
`ifdef SCAN_SEQ_DOWN_EN
    .dir(dir),
`endif
    .A(A0), .B(B0), .C(C0), .D(D0), .en(en0), .busy(busy0), .done(done0)
  );

  scan_seq_416 #(.DWELL(1), .ONESHOT(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
`ifdef SCAN_SEQ_DOWN_EN
    .dir(dir),
`endif
    .A(A1), .B(B1), .C(C1), .D(D1), .en(en1), .busy(busy1), .done(done1)
  );

`ifdef SCAN_SEQ_DOWN_EN
  logic A2, B2, C2, D2, en2, busy2, done2;
  logic [6:0] v2;
  assign v2 = {D2, C2, B2, A2, en2, busy2, done2};
  scan_seq_416 #(.DWELL(2), .ONESHOT(1)) u2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
    .A(A2), .B(B2), .C(C2), .D(D2), .en(en2), .busy(busy2), .done(done2)
  );
`endif

  // Reference model: a running sweep is described only by elapsed cycles t since start
  int mdw[3]  = '{4, 1, 2};
  bit mone[3] = '{1'b1, 1'b0, 1'b1};
  bit mrun[3], mdone[3], mdir[3];
  int mt[3];

  task automatic mdl_update();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mrun[i] = 0; mt[i] = 0; mdone[i] = 0;
      end else if (mdone[i]) begin
        mdone[i] = 0;
      end else if (!mrun[i]) begin
        if (start) begin
          mrun[i] = 1; mt[i] = 0; mdir[i] = dir;
        end
      end else if (stop) begin
        mrun[i] = 0;
      end else begin
        mt[i]++;
        if (mt[i] == 16 * mdw[i]) begin
          mt[i] = 0;
          if (mone[i]) begin
            mrun[i] = 0; mdone[i] = 1;
          end
        end
      end
    end
  endtask

  function automatic logic [6:0] mdl_vec(input int i);
    int k;
    logic [3:0] c;
    k = (mt[i] / mdw[i]) % 16;
    c = mdir[i] ? 4'(15 - k) : 4'(k);
    if (!mrun[i]) c = 4'd0;
    return {c, mrun[i], mrun[i], mdone[i]};
  endfunction

  task automatic step();
    mdl_update();
    @(posedge clk);
    #1;
  endtask

  task automatic run_n(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; stop = 1'b1;
    run_n(2);
    n_checks++;
    if (v0 !== 7'd0) begin n_fail++; $display("FAIL reset_u0: got %b expected %b", v0, 7'd0); end
    n_checks++;
    if (v1 !== 7'd0) begin n_fail++; $display("FAIL reset_u1: got %b expected %b", v1, 7'd0); end
    start = 1'b0; stop = 1'b0;
    do_reset();
  endtask

  task automatic test_sweep_oneshot();
    logic [6:0] exp;
    do_reset();
    stop = 1'b1;   // ignored in IDLE
    step();
    stop = 1'b0;
    n_checks++;
    if (v0 !== 7'd0) begin n_fail++; $display("FAIL idle_u0: got %b expected %b", v0, 7'd0); end
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 64; c++) begin
      exp = {4'(c / 4), 3'b110};
      n_checks++;
      if (v0 !== exp) begin n_fail++; $display("FAIL sweep c=%0d: got %b expected %b", c, v0, exp); end
      step();
    end
    n_checks++;
    if (v0 !== 7'b0000_001) begin n_fail++; $display("FAIL sweep_done: got %b expected %b", v0, 7'b0000_001); end
    step();
    n_checks++;
    if (v0 !== 7'd0) begin n_fail++; $display("FAIL sweep_idle: got %b expected %b", v0, 7'd0); end
  endtask

  task automatic test_wrap();
    logic [6:0] exp;
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      exp = {4'(c % 16), 3'b110};
      n_checks++;
      if (v1 !== exp) begin n_fail++; $display("FAIL wrap c=%0d: got %b expected %b", c, v1, exp); end
      step();
    end
  endtask

  task automatic test_stop();
    int off;
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    off = $urandom_range(0, 3);
    run_n(20 + off);
    n_checks++;
    if (v0 !== {4'd5, 3'b110}) begin n_fail++; $display("FAIL stop_pre: got %b expected %b", v0, {4'd5, 3'b110}); end
    stop = 1'b1; step(); stop = 1'b0;
    n_checks++;
    if (v0 !== 7'd0) begin n_fail++; $display("FAIL stop_idle: got %b expected %b", v0, 7'd0); end
    step();
    n_checks++;
    if (v0 !== 7'd0) begin n_fail++; $display("FAIL stop_nodone: got %b expected %b", v0, 7'd0); end
  endtask

  task automatic test_rst_mid();
    int off;
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    off = $urandom_range(0, 3);
    run_n(40 + off);
    n_checks++;
    if (v0 !== {4'd10, 3'b110}) begin n_fail++; $display("FAIL rstmid_pre: got %b expected %b", v0, {4'd10, 3'b110}); end
    rst = 1'b1; start = 1'b1; step();
    n_checks++;
    if (v0 !== 7'd0) begin n_fail++; $display("FAIL rstmid_clear: got %b expected %b", v0, 7'd0); end
    rst = 1'b0; step(); start = 1'b0;
    n_checks++;
    if (v0 !== {4'd0, 3'b110}) begin n_fail++; $display("FAIL rstmid_restart: got %b expected %b", v0, {4'd0, 3'b110}); end
  endtask

  task automatic test_stop_last();
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    run_n(30);
    start = 1'b1; step(); start = 1'b0;   // ignored while running
    n_checks++;
    if (v0 !== {4'd7, 3'b110}) begin n_fail++; $display("FAIL start_in_run: got %b expected %b", v0, {4'd7, 3'b110}); end
    run_n(32);
    n_checks++;
    if (v0 !== {4'd15, 3'b110}) begin n_fail++; $display("FAIL last_pre: got %b expected %b", v0, {4'd15, 3'b110}); end
    stop = 1'b1; step(); stop = 1'b0;
    n_checks++;
    if (v0 !== 7'd0) begin n_fail++; $display("FAIL last_stop: got %b expected %b", v0, 7'd0); end
    step();
    n_checks++;
    if (v0 !== 7'd0) begin n_fail++; $display("FAIL last_nodone: got %b expected %b", v0, 7'd0); end
  endtask

`ifdef SCAN_SEQ_DOWN_EN
  task automatic test_down();
    logic [6:0] exp;
    do_reset();
    dir = 1'b1; start = 1'b1; step(); start = 1'b0; dir = 1'b0;
    for (int c = 0; c < 32; c++) begin
      exp = {4'(15 - c / 2), 3'b110};
      n_checks++;
      if (v2 !== exp) begin n_fail++; $display("FAIL down c=%0d: got %b expected %b", c, v2, exp); end
      step();
    end
    n_checks++;
    if (v2 !== 7'b0000_001) begin n_fail++; $display("FAIL down_done: got %b expected %b", v2, 7'b0000_001); end
  endtask
`endif

  task automatic test_random();
    logic [6:0] e0, e1;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (n < 2000) begin
        rst  = ($urandom_range(0, 63) == 0);
        stop = ($urandom_range(0, 15) == 0);
      end else begin
        rst  = ($urandom_range(0, 511) == 0);
        stop = ($urandom_range(0, 255) == 0);
      end
      start = ($urandom_range(0, 3) == 0);
`ifdef SCAN_SEQ_DOWN_EN
      dir = 1'($urandom_range(0, 1));
`endif
      step();
      e0 = mdl_vec(0);
      e1 = mdl_vec(1);
      n_checks++;
      if (v0 !== e0) begin n_fail++; $display("FAIL rand_u0 n=%0d: got %b expected %b", n, v0, e0); end
      n_checks++;
      if (v1 !== e1) begin n_fail++; $display("FAIL rand_u1 n=%0d: got %b expected %b", n, v1, e1); end
`ifdef SCAN_SEQ_DOWN_EN
      n_checks++;
      if (v2 !== mdl_vec(2)) begin n_fail++; $display("FAIL rand_u2 n=%0d: got %b expected %b", n, v2, mdl_vec(2)); end
`endif
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sweep_oneshot();
    test_wrap();
    test_stop();
    test_rst_mid();
    test_stop_last();
`ifdef SCAN_SEQ_DOWN_EN
    test_down();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
